// File: rtl/cic_decimator_n.sv
// cic_decimator_n
//   N-stage CIC decimator. It has a valid-qualified input, a decimation ratio
//   that can change at run time, and round-half-up output scaling with
//   saturation. It emits one output word per R_eff accepted input samples.
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active low
//   in_valid   in_data holds a new sample this cycle
//   in_data    signed input sample (IN_W bits)
//   dec_ratio  requested decimation ratio; clamped to [2, 2^MAX_DEC_LOG2]
//   gain       left gain; the right shift applied is ACC_W-OUT_W-gain
//   out_data   signed, scaled and saturated output (OUT_W bits)
//   out_valid  one-cycle strobe that marks a new out_data
//   out_clk    clock at the decimated rate with about 50% duty
//   sat        out_data was clipped; qualified by out_valid
module cic_decimator_n #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 12,
    parameter int STAGES       = 5,
    parameter int MAX_DEC_LOG2 = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [15:0]      dec_ratio,
    input  logic [7:0]       gain,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_clk,
    output logic             sat
);
    localparam int ACC_W = IN_W + STAGES * MAX_DEC_LOG2;
    localparam int RW    = MAX_DEC_LOG2 + 1;

    localparam logic [15:0]           SH_MAX  = 16'(ACC_W - OUT_W);
    localparam logic [RW-1:0]         R_ONE   = {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Limit the requested ratio to the range the accumulator width supports.
    function automatic logic [RW-1:0] clamp_ratio(input logic [15:0] r);
        logic [16:0] lim;
        lim = 17'd1 << MAX_DEC_LOG2;
        if (r < 16'd2) begin
            clamp_ratio = {{(RW-2){1'b0}}, 2'd2};
        end else if ({1'b0, r} > lim) begin
            clamp_ratio = lim[RW-1:0];
        end else begin
            clamp_ratio = r[RW-1:0];
        end
    endfunction

    logic signed [ACC_W-1:0] in_ext_s;
    logic signed [ACC_W-1:0] integ_next_s [STAGES];
    logic signed [ACC_W-1:0] integ_r      [STAGES];
    logic [RW-1:0]           count_r;
    logic [RW-1:0]           count_inc_s;
    logic [RW-1:0]           reff_r;
    logic signed [ACC_W-1:0] snap_r;
    logic                    snap_vld_r;
    logic signed [ACC_W-1:0] comb_in_s [STAGES];
    logic [STAGES-1:0]       vin_s;
    logic signed [ACC_W-1:0] comb_r    [STAGES];
    logic signed [ACC_W-1:0] dly_r     [STAGES];
    logic [STAGES-1:0]       vld_r;
    logic [15:0]             sh_s;
    logic signed [ACC_W:0]   ext_s;
    logic signed [ACC_W:0]   bias_s;
    logic signed [ACC_W:0]   rnd_s;
    logic signed [ACC_W:0]   rnd_r;
    logic                    rnd_vld_r;

    assign in_ext_s    = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign count_inc_s = count_r + R_ONE;

    // Integrator cascade. Each stage adds the already-updated value of the
    // stage before it, so the last stage includes the current sample.
    always_comb begin
        logic signed [ACC_W-1:0] run_v;
        run_v = in_ext_s;
        for (int k = 0; k < STAGES; k++) begin
            run_v           = integ_r[k] + run_v;
            integ_next_s[k] = run_v;
        end
    end

    // Integrator state, sample counter, out_clk and ratio reload at the period boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_r[k] <= '0;
            end
            count_r    <= '0;
            reff_r     <= clamp_ratio(dec_ratio);
            out_clk    <= 1'b0;
            snap_r     <= '0;
            snap_vld_r <= 1'b0;
        end else begin
            snap_vld_r <= 1'b0;
            if (in_valid) begin
                for (int k = 0; k < STAGES; k++) begin
                    integ_r[k] <= integ_next_s[k];
                end
                if (count_r == reff_r - R_ONE) begin
                    count_r    <= '0;
                    out_clk    <= 1'b1;
                    reff_r     <= clamp_ratio(dec_ratio);
                    snap_r     <= integ_next_s[STAGES-1];
                    snap_vld_r <= 1'b1;
                end else begin
                    count_r <= count_inc_s;
                    if (count_inc_s == (reff_r >> 1)) begin
                        out_clk <= 1'b0;
                    end
                end
            end
        end
    end

    // Route the input of each comb stage: the snapshot feeds stage 0, and the previous stage feeds the rest.
    always_comb begin
        comb_in_s[0] = snap_r;
        vin_s[0]     = snap_vld_r;
        for (int k = 1; k < STAGES; k++) begin
            comb_in_s[k] = comb_r[k-1];
            vin_s[k]     = vld_r[k-1];
        end
    end

    // Comb pipeline. A stage moves only when its token arrives, and the
    // snapshots are at least two cycles apart, so tokens never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_r[k] <= '0;
                dly_r[k]  <= '0;
            end
            vld_r <= '0;
        end else begin
            vld_r <= vin_s;
            for (int k = 0; k < STAGES; k++) begin
                if (vin_s[k]) begin
                    comb_r[k] <= comb_in_s[k] - dly_r[k];
                    dly_r[k]  <= comb_in_s[k];
                end
            end
        end
    end

    // Rounding shift. The work is one bit wider so the half-LSB bias cannot overflow.
    always_comb begin
        if ({8'd0, gain} > SH_MAX) begin
            sh_s = 16'd0;
        end else begin
            sh_s = SH_MAX - {8'd0, gain};
        end
        ext_s = {comb_r[STAGES-1][ACC_W-1], comb_r[STAGES-1]};
        if (sh_s != 16'd0) begin
            bias_s = {{ACC_W{1'b0}}, 1'b1} << (sh_s - 16'd1);
        end else begin
            bias_s = '0;
        end
        rnd_s = (ext_s + bias_s) >>> sh_s;
    end

    // Register the rounded value. This stage sits between the comb and the saturation step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd_r     <= '0;
            rnd_vld_r <= 1'b0;
        end else begin
            rnd_vld_r <= vld_r[STAGES-1];
            if (vld_r[STAGES-1]) begin
                rnd_r <= rnd_s;
            end
        end
    end

    // Saturating output register. Data and sat hold their values between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rnd_vld_r;
            if (rnd_vld_r) begin
                if (rnd_r > OUT_MAX) begin
                    out_data <= OUT_MAX[OUT_W-1:0];
                    sat      <= 1'b1;
                end else if (rnd_r < OUT_MIN) begin
                    out_data <= OUT_MIN[OUT_W-1:0];
                    sat      <= 1'b1;
                end else begin
                    out_data <= rnd_r[OUT_W-1:0];
                    sat      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator_n.sv
// tb_cic_decimator_n
//   Bench for cic_decimator_n. The bench pushes expected outputs into a
//   scoreboard as it issues stimulus. A monitor process compares each
//   out_valid strobe against the scoreboard, and compares out_clk on every cycle.
module tb_cic_decimator_n;
    localparam int IN_W         = 12;
    localparam int OUT_W        = 12;
    localparam int STAGES       = 5;
    localparam int MAX_DEC_LOG2 = 14;
    localparam int ACC_W        = IN_W + STAGES * MAX_DEC_LOG2;
    localparam int LAT          = STAGES + 2;
    localparam int OMAX         = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN         = -(1 << (OUT_W - 1));

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [IN_W-1:0]  in_data   = '0;
    logic [15:0]      dec_ratio = 16'd16;
    logic [7:0]       gain      = 8'd50;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_clk;
    logic             sat;

    typedef struct {
        int data;
        bit s;
        int due;
    } exp_t;

    exp_t sb[$];
    bit   oclk_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_cyc = -1;
    int prev_cyc = -1;
    int last_data = 0;
    bit last_sat = 1'b0;

    logic signed [ACC_W-1:0] m_int [STAGES];
    logic signed [ACC_W-1:0] m_cd  [STAGES];
    int m_cnt = 0;
    int m_reff = 2;
    bit m_oclk = 1'b0;
    bit m_snap = 1'b0;

    int ratios [8] = '{0, 1, 2, 3, 4, 5, 7, 16};

    cic_decimator_n #(
        .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .MAX_DEC_LOG2(MAX_DEC_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .dec_ratio(dec_ratio), .gain(gain), .out_data(out_data),
        .out_valid(out_valid), .out_clk(out_clk), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp_r(input int r);
        if (r < 2) return 2;
        if (r > (1 << MAX_DEC_LOG2)) return 1 << MAX_DEC_LOG2;
        return r;
    endfunction

    // Scale one comb result: add half an LSB, shift right arithmetically, then clip.
    function automatic void scale(input logic signed [ACC_W-1:0] c, input int g,
                                  output int y, output bit s);
        int sh;
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] b;
        sh = (g > ACC_W - OUT_W) ? 0 : ACC_W - OUT_W - g;
        v = {c[ACC_W-1], c};
        b = '0;
        if (sh > 0) b[sh-1] = 1'b1;
        v = (v + b) >>> sh;
        if (v > OMAX) begin
            y = OMAX; s = 1'b1;
        end else if (v < OMIN) begin
            y = OMIN; s = 1'b1;
        end else begin
            y = int'(v[31:0]); s = 1'b0;
        end
    endfunction

    // Model of the next clock edge, built from the inputs the bench is about to apply.
    function automatic void model_step();
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] t;
        int y;
        bit sf;
        m_snap = 1'b0;
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                m_int[k] = '0;
                m_cd[k]  = '0;
            end
            m_cnt  = 0;
            m_oclk = 1'b0;
            m_reff = clamp_r(int'(dec_ratio));
            sb.delete();
        end else if (in_valid) begin
            s = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
            for (int k = 0; k < STAGES; k++) begin
                m_int[k] = m_int[k] + s;
                s = m_int[k];
            end
            if (m_cnt == m_reff - 1) begin
                m_cnt  = 0;
                m_oclk = 1'b1;
                m_reff = clamp_r(int'(dec_ratio));
                m_snap = 1'b1;
                for (int k = 0; k < STAGES; k++) begin
                    t = s - m_cd[k];
                    m_cd[k] = s;
                    s = t;
                end
                scale(s, int'(gain), y, sf);
                sb.push_back('{data: y, s: sf, due: cyc + 1 + LAT});
            end else begin
                m_cnt++;
                if (m_cnt == m_reff / 2) m_oclk = 1'b0;
            end
        end
        oclk_q.push_back(m_oclk);
    endfunction

    task automatic drive(input bit r, input bit v, input int d);
        rst_n    = r;
        in_valid = v;
        in_data  = d[IN_W-1:0];
        model_step();
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) drive(1'b1, 1'b0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare out_clk on every cycle, and compare each out_valid strobe against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        int act;
        bit eo;
        if (oclk_q.size() > 0) begin
            eo = oclk_q.pop_front();
            n_chk++;
            if (out_clk !== eo) begin
                n_fail++;
                $display("FAIL out_clk: got %0b expected %0b (cycle %0d)", out_clk, eo, cyc);
            end
        end
        if (out_valid !== 1'b0) begin
            act = int'($signed(out_data));
            prev_cyc  = last_cyc;
            last_cyc  = cyc;
            last_data = act;
            last_sat  = sat;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                n_chk++;
                if (act != e.data) begin
                    n_fail++;
                    $display("FAIL out_data: got %0d expected %0d (cycle %0d)", act, e.data, cyc);
                end
                n_chk++;
                if (sat !== e.s) begin
                    n_fail++;
                    $display("FAIL sat: got %0b expected %0b (cycle %0d)", sat, e.s, cyc);
                end
                n_chk++;
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, e.due);
                end
            end
        end
    end

    initial begin : stimulus
        int hi;
        int guard;
        int er;

        // Reset state
        dec_ratio = 16'd16;
        gain      = 8'd50;
        repeat (2) drive(1'b0, 1'b0, 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_clk", int'(out_clk), 0);

        // DC, R=16, gain=50: shift 20 equals 16^5, so the steady output is 100
        repeat (16 * 10) drive(1'b1, 1'b1, 100);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 100);
            if (out_clk === 1'b1) hi++;
        end
        drain(12);
        chk("dc_steady", last_data, 100);
        chk("dc_sat", int'(last_sat), 0);
        chk("dc_period", last_cyc - prev_cyc, 16);
        chk("out_clk_duty", hi, 8);

        // Saturation, both rails
        gain = 8'd51;
        repeat (16 * 8) drive(1'b1, 1'b1, 2047);
        drain(12);
        chk("sat_pos_data", last_data, 2047);
        chk("sat_pos_flag", int'(last_sat), 1);
        repeat (16 * 10) drive(1'b1, 1'b1, -2048);
        drain(12);
        chk("sat_neg_data", last_data, -2048);
        chk("sat_neg_flag", int'(last_sat), 1);

        // Gated input, one valid sample in three
        gain = 8'd50;
        for (int i = 0; i < 48 * 10; i++) drive(1'b1, (i % 3) == 0, 100);
        drain(12);
        chk("gated_steady", last_data, 100);
        chk("gated_period", last_cyc - prev_cyc, 48);

        // Ratio change in the middle of a period, then steady operation at R=8
        repeat (16 * 3 + 5) drive(1'b1, 1'b1, 100);
        dec_ratio = 16'd8;
        repeat (16 * 5) drive(1'b1, 1'b1, 100);
        drain(12);
        chk("ratio8_period", last_cyc - prev_cyc, 8);
        gain = 8'd55;
        repeat (8 * 10) drive(1'b1, 1'b1, 100);
        drain(12);
        chk("r8_steady", last_data, 100);
        chk("r8_sat", int'(last_sat), 0);

        // Reset asserted three edges after a snapshot
        guard = 0;
        m_snap = 1'b0;
        while (!m_snap && guard < 40) begin
            drive(1'b1, 1'b1, 100);
            guard++;
        end
        chk("snapshot_seen", int'(m_snap), 1);
        repeat (2) drive(1'b1, 1'b1, 100);
        drive(1'b0, 1'b1, 100);
        er = cyc;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_sat", int'(sat), 0);
        chk("midrst_out_clk", int'(out_clk), 0);
        repeat (8 + LAT + 2) drive(1'b1, 1'b1, 100);
        chk("post_reset_latency", last_cyc - er, 8 + LAT);

        // Random data, gains and ratios, including ratios that the clamp raises to 2
        for (int seg = 0; seg < 12; seg++) begin
            drain(12);
            gain      = 8'($urandom_range(40, 80));
            dec_ratio = 16'(ratios[$urandom_range(0, 7)]);
            repeat (80) drive(1'b1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)));
        end

        // Largest ratio: a request above the limit clamps to 2^MAX_DEC_LOG2
        drain(12);
        dec_ratio = 16'hFFFF;
        gain      = 8'd0;
        drive(1'b0, 1'b0, 0);
        er = cyc;
        repeat ((1 << MAX_DEC_LOG2) + LAT + 3) drive(1'b1, 1'b1, int'($urandom_range(0, 4095)));
        chk("max_ratio_latency", last_cyc - er, (1 << MAX_DEC_LOG2) + LAT);

        // Ratio 1 clamps to 2, with no shift applied
        drain(12);
        dec_ratio = 16'd1;
        gain      = 8'd70;
        drive(1'b0, 1'b0, 0);
        repeat (30) drive(1'b1, 1'b1, int'($urandom_range(0, 4095)));
        drain(12);
        chk("min_ratio_period", last_cyc - prev_cyc, 2);

        drain(15);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
